spi_cmd_rx: RTL and testbench

SPI slave receiver that sits directly upstream of the trigger-pulse generator in the Qsys system.
- Samples the external SPI_CS / SPI_CLK / SPI_MOSI pins in the CLK50M domain.
- Assembles fixed-length command words.
- Presents each word on a valid/ready handshake for the pulse generator to consume.
- Flags framing and overrun errors as single-cycle pulses.

---
 rtl/spi_cmd_rx.sv | 174 +++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: SPI mode-0 slave receiver, CLK50M-domain oversampling, valid/ready word output.
// Define SPI_CMD_RX_PARITY_EN to append an odd-parity bit to every frame and enable PAR_ERR.
module spi_cmd_rx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK50M,
    input  logic              RESET,
    input  logic              SPI_CS,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic              FRAME_ERR,
    output logic              OVERRUN,
    output logic              PAR_ERR
);

`ifdef SPI_CMD_RX_PARITY_EN
    localparam int unsigned FRAME_W = DATA_W + 1;
`else
    localparam int unsigned FRAME_W = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, clk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, clk_prev_q;
    logic                   cs_s, clk_s, mosi_s;
    logic                   cs_fall, cs_rise, clk_rise;

    state_t                 state_q, state_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   frame_err_q, frame_err_d;

    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_W-1:0]      word;
    logic                   word_ok;

    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            cs_sync_q   <= '1;
            clk_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            clk_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            cs_prev_q   <= cs_s;
            clk_prev_q  <= clk_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign clk_rise = clk_s & ~clk_prev_q;

    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // CS release takes priority over a coincident SPI_CLK edge.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                shift_d = '0;
                cnt_d   = '0;
                if (cs_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    shift_d     = '0;
                    cnt_d       = '0;
                    frame_err_d = (cnt_q != '0);
                end else if (clk_rise) begin
                    shift_d = {shift_q[FRAME_W-2:0], mosi_s};
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef SPI_CMD_RX_PARITY_EN
    logic par_err_q;

    assign word    = shift_q[FRAME_W-1:1];
    assign word_ok = ^shift_q;

    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= done_q & ~word_ok;
        end
    end

    assign PAR_ERR = par_err_q;
`else
    assign word    = shift_q;
    assign word_ok = 1'b1;
    assign PAR_ERR = 1'b0;
`endif

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && RX_READY) begin
            valid_d = 1'b0;
        end
        if (done_q && word_ok) begin
            if (!valid_q || RX_READY) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign RX_DATA   = data_q;
    assign RX_VALID  = valid_q;
    assign OVERRUN   = overrun_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb_spi_cmd_rx: directed plus randomized SPI frames against a cycle-timed reference model.
// Honours SPI_CMD_RX_PARITY_EN the same way as the design.
module tb_spi_cmd_rx;
    localparam int DATA_W = 16;
    localparam int SYNC   = 2;
`ifdef SPI_CMD_RX_PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif

    logic              CLK50M   = 1'b0;
    logic              RESET    = 1'b0;
    logic              SPI_CS   = 1'b1;
    logic              SPI_CLK  = 1'b0;
    logic              SPI_MOSI = 1'b0;
    logic              RX_READY = 1'b0;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_VALID, FRAME_ERR, OVERRUN, PAR_ERR;

    int checks = 0;
    int errors = 0;

    int                cyc           = 0;
    int                comp_at       = -1;
    int                fe_at         = -1;
    int                bits_in_frame = 0;
    int                half          = 5;
    int                ready_mode    = 0;
    logic              ready_dir     = 1'b1;
    logic [DATA_W-1:0] pend_word     = '0;
    logic              pend_ok       = 1'b1;

    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    logic              m_ovr   = 1'b0;
    logic              m_fe    = 1'b0;
    logic              m_pe    = 1'b0;

    spi_cmd_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .CLK50M   (CLK50M),
        .RESET    (RESET),
        .SPI_CS   (SPI_CS),
        .SPI_CLK  (SPI_CLK),
        .SPI_MOSI (SPI_MOSI),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN  (OVERRUN),
        .PAR_ERR  (PAR_ERR)
    );

    always #10 CLK50M = ~CLK50M;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    // Reference: a word whose last bit rises at the pin at cycle k takes effect at edge
    // k+SYNC+2; a partial-frame CS release at cycle k pulses FRAME_ERR after edge k+SYNC+1.
    always @(posedge CLK50M) begin
        logic hs;
        cyc   = cyc + 1;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_pe  = 1'b0;
        if (RESET) begin
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            hs = m_valid && RX_READY;
            if (cyc == fe_at) m_fe = 1'b1;
            if (cyc == comp_at) begin
                if (!pend_ok) begin
                    m_pe = 1'b1;
                end else if (!m_valid || RX_READY) begin
                    m_data  = pend_word;
                    m_valid = 1'b1;
                    hs      = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (hs) m_valid = 1'b0;
        end
    end

    always @(negedge CLK50M) begin
        case (ready_mode)
            1:       RX_READY = 1'($urandom_range(0, 1));
            2:       RX_READY = (comp_at == cyc + 1);
            default: RX_READY = ready_dir;
        endcase
    end

    always @(negedge CLK50M) begin
        #5;
        if (RESET) begin
            chk("rst_valid", 32'(RX_VALID), 32'd0);
            chk("rst_data", 32'(RX_DATA), 32'd0);
            chk("rst_ovr", 32'(OVERRUN), 32'd0);
            chk("rst_fe", 32'(FRAME_ERR), 32'd0);
            chk("rst_pe", 32'(PAR_ERR), 32'd0);
        end else begin
            chk("valid", 32'(RX_VALID), 32'(m_valid));
            chk("data", 32'(RX_DATA), 32'(m_data));
            chk("overrun", 32'(OVERRUN), 32'(m_ovr));
            chk("frame_err", 32'(FRAME_ERR), 32'(m_fe));
            chk("par_err", 32'(PAR_ERR), 32'(m_pe));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK50M);
    endtask

    task automatic cs_low();
        SPI_CS        = 1'b0;
        bits_in_frame = 0;
        wait_n(4);
    endtask

    task automatic cs_high();
        SPI_CS = 1'b1;
        if (bits_in_frame % FL != 0) fe_at = cyc + SYNC + 1;
        wait_n(6);
    endtask

    task automatic send_bit(input logic b);
        SPI_MOSI = b;
        wait_n(half);
        SPI_CLK = 1'b1;
        bits_in_frame++;
        if (bits_in_frame % FL == 0) comp_at = cyc + SYNC + 2;
        wait_n(half);
        SPI_CLK = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input logic good);
        logic [FL-1:0] fr;
`ifdef SPI_CMD_RX_PARITY_EN
        fr = {w, ~(^w) ^ ~good};
`else
        fr = w;
`endif
        for (int i = FL - 1; i >= 0; i--) begin
            if (i == 0) begin
                pend_word = w;
                pend_ok   = good;
            end
            send_bit(fr[i]);
        end
    endtask

    task automatic idle_clocks(input int n);
        repeat (n) begin
            wait_n(4);
            SPI_CLK = 1'b1;
            wait_n(4);
            SPI_CLK = 1'b0;
        end
        wait_n(2);
    endtask

    initial begin
        RESET = 1'b1;
        wait_n(4);
        RESET = 1'b0;
        wait_n(4);

        // single word, consumer always ready
        ready_dir = 1'b1;
        cs_low(); send_word(16'hA5C3, 1'b1); cs_high();
        wait_n(10);

        // two words in one frame with consumer stalled: second overruns
        ready_dir = 1'b0;
        cs_low(); send_word(16'h1234, 1'b1); send_word(16'hBEEF, 1'b1); cs_high();
        wait_n(10);
        ready_dir = 1'b1;
        wait_n(10);

        // partial frame then a clean one
        cs_low();
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
        cs_high();
        cs_low(); send_word(16'h00FF, 1'b1); cs_high();
        wait_n(10);

        // reset in the middle of a frame, CS held low across reset
        cs_low();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        RESET = 1'b1;
        wait_n(3);
        RESET = 1'b0;
        bits_in_frame = 0;
        wait_n(8);
        send_word(16'h8001, 1'b1); cs_high();
        wait_n(10);

        // completion coincides with a handshake on the held word
        ready_dir = 1'b0;
        cs_low(); send_word(16'h1111, 1'b1); cs_high();
        wait_n(4);
        ready_mode = 2;
        cs_low(); send_word(16'h2222, 1'b1); cs_high();
        wait_n(4);
        ready_mode = 0;
        ready_dir  = 1'b1;
        wait_n(10);

`ifdef SPI_CMD_RX_PARITY_EN
        cs_low(); send_word(16'h0001, 1'b1); cs_high();
        cs_low(); send_word(16'h0001, 1'b0); cs_high();
        wait_n(10);
`endif

        idle_clocks(3);

        ready_mode = 1;
        for (int f = 0; f < 30; f++) begin
            int nw, np;
            half = $urandom_range(4, 7);
            nw   = $urandom_range(0, 3);
            np   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FL - 1) : 0;
            cs_low();
            for (int w = 0; w < nw; w++) begin
                logic good;
                good = 1'b1;
`ifdef SPI_CMD_RX_PARITY_EN
                good = ($urandom_range(0, 3) != 0);
`endif
                send_word(DATA_W'($urandom), good);
            end
            for (int b = 0; b < np; b++) send_bit(1'($urandom_range(0, 1)));
            cs_high();
            if ($urandom_range(0, 4) == 0) idle_clocks($urandom_range(1, 3));
        end

        ready_mode = 0;
        ready_dir  = 1'b1;
        wait_n(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
